// File: rtl/light_pen_frontend_pkg.sv
// Shared state codes, default parameters and one-hot helpers for the light-pen front end.
// The optional statistics counters in the top level are enabled with LPEN_STATS_EN.
package light_pen_frontend_pkg;

  typedef enum logic [1:0] {
    LPEN_IDLE = 2'd0,
    LPEN_CAND = 2'd1,
    LPEN_ARM  = 2'd2,
    LPEN_LOCK = 2'd3
  } lpen_state_t;

  localparam int SYNC_STAGES_DEF    = 2;
  localparam int FILTER_LEN_DEF     = 4;
  localparam int LAT_CYC_DEF        = 3;
  localparam int CONFIRM_FRAMES_DEF = 2;

  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  function automatic logic [2:0] onehot_enc(input logic [7:0] v);
    logic [2:0] e;
    e = '0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) e = 3'(i);
    end
    return e;
  endfunction

endpackage

// File: rtl/light_pen_frontend_glitch_filter.sv
// Synchronises the raw pen detector and only follows it after FILTER_LEN identical samples.
// Emits a one-cycle rise pulse and a one-cycle pulse for every rejected short excursion.
module light_pen_frontend_glitch_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pen_in,
  output logic pen_level,
  output logic rise,
  output logic glitch
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [3:0]             run_cnt;
  logic                   pen_s;

  assign pen_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      run_cnt   <= '0;
      pen_level <= 1'b0;
      rise      <= 1'b0;
      glitch    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pen_in};
      rise   <= 1'b0;
      glitch <= 1'b0;
      if (pen_s != pen_level) begin
        if (run_cnt == 4'(FILTER_LEN - 1)) begin
          pen_level <= pen_s;
          run_cnt   <= '0;
          rise      <= pen_s;
        end else begin
          run_cnt <= run_cnt + 4'd1;
        end
      end else begin
        // A run that ended before reaching FILTER_LEN was a rejected glitch.
        run_cnt <= '0;
        glitch  <= (run_cnt != 4'd0);
      end
    end
  end

endmodule

// File: rtl/light_pen_frontend.sv
// Light-pen front end: filters the pen, matches its edges to a delayed scan address,
// confirms a pixel over frames and fires a one-cycle we. LPEN_STATS_EN adds hit/glitch counters.
module light_pen_frontend
  import light_pen_frontend_pkg::*;
#(
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int FILTER_LEN     = FILTER_LEN_DEF,
  parameter int LAT_CYC        = LAT_CYC_DEF,
  parameter int CONFIRM_FRAMES = CONFIRM_FRAMES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pen_in,
  input  logic       pen_en,
  input  logic [7:0] led_row,
  input  logic [7:0] led_col,
  output logic       we,
  output logic [2:0] hit_row,
  output logic [2:0] hit_col,
  output logic       hit_valid,
  output logic       pen_level,
  output logic [1:0] fsm_state
`ifdef LPEN_STATS_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] glitch_cnt
`endif
);

  localparam int       D   = SYNC_STAGES + FILTER_LEN + LAT_CYC;
  localparam logic [2:0] CF = 3'(CONFIRM_FRAMES);

  logic             rise, glitch;
  logic             addr_ok, frame_tick;
  logic [5:0]       addr, last_addr_q, daddr;
  logic             dok;
  logic [D-1:0][6:0] dl_q;

  lpen_state_t state_q, state_d;
  logic [5:0]  cand_q, cand_d;
  logic [2:0]  cnt_q, cnt_d, cnt_inc;
  logic        hit_q, hit_d, we_q, we_d;
  logic [2:0]  hit_row_d, hit_col_d;
  logic        pen_hit, at_cand, other, hit_eff;

  light_pen_frontend_glitch_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .pen_in   (pen_in),
    .pen_level(pen_level),
    .rise     (rise),
    .glitch   (glitch)
  );

  assign addr_ok    = is_onehot(led_row) && is_onehot(led_col);
  assign addr       = {onehot_enc(led_row), onehot_enc(led_col)};
  // last_addr_q only follows valid addresses so blanking never fakes a frame start.
  assign frame_tick = addr_ok && (addr == 6'd0) && (last_addr_q != 6'd0);
  assign daddr      = dl_q[D-1][5:0];
  assign dok        = dl_q[D-1][6];

  assign pen_hit = rise && dok;
  assign at_cand = pen_hit && (daddr == cand_q);
  assign other   = pen_hit && (daddr != cand_q);
  assign hit_eff = hit_q || at_cand;
  assign cnt_inc = (cnt_q >= CF) ? cnt_q : cnt_q + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_q        <= '0;
      last_addr_q <= '0;
    end else begin
      dl_q <= {dl_q[D-2:0], {addr_ok, addr}};
      if (addr_ok) last_addr_q <= addr;
    end
  end

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    hit_d     = hit_q;
    we_d      = 1'b0;
    hit_row_d = hit_row;
    hit_col_d = hit_col;
    if (!pen_en) begin
      state_d = LPEN_IDLE;
      cnt_d   = '0;
      hit_d   = 1'b0;
    end else begin
      // hit_q means "current frame already hit cand"; a rise coinciding with
      // frame_tick belongs to the frame that is ending.
      case (state_q)
        LPEN_IDLE: begin
          if (pen_hit) begin
            state_d = LPEN_CAND;
            cand_d  = daddr;
            cnt_d   = 3'd1;
            hit_d   = !frame_tick;
          end
        end
        LPEN_CAND: begin
          if (other) begin
            cand_d = daddr;
            cnt_d  = 3'd1;
            hit_d  = !frame_tick;
          end else begin
            if (at_cand && !hit_q) cnt_d = cnt_inc;
            if (frame_tick) begin
              hit_d = 1'b0;
              if (!hit_eff) begin
                state_d = LPEN_IDLE;
                cnt_d   = '0;
              end
            end else if (at_cand) begin
              hit_d = 1'b1;
            end
          end
        end
        LPEN_ARM: begin
          if (addr_ok && (addr == cand_q)) begin
            we_d      = 1'b1;
            hit_row_d = cand_q[5:3];
            hit_col_d = cand_q[2:0];
            state_d   = LPEN_LOCK;
            hit_d     = 1'b0;
            cnt_d     = '0;
          end
        end
        LPEN_LOCK: begin
          if (other) begin
            state_d = LPEN_CAND;
            cand_d  = daddr;
            cnt_d   = 3'd1;
            hit_d   = !frame_tick;
          end else if (frame_tick) begin
            hit_d = 1'b0;
            if (!hit_eff) state_d = LPEN_IDLE;
          end else if (at_cand) begin
            hit_d = 1'b1;
          end
        end
        default: state_d = LPEN_IDLE;
      endcase
      if ((state_d == LPEN_CAND) && (cnt_d == CF)) begin
        state_d = LPEN_ARM;
        hit_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LPEN_IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      we_q    <= 1'b0;
      hit_row <= '0;
      hit_col <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      we_q    <= we_d;
      hit_row <= hit_row_d;
      hit_col <= hit_col_d;
    end
  end

  assign we        = we_q && pen_en;
  assign hit_valid = (state_q == LPEN_LOCK);
  assign fsm_state = state_q;

`ifdef LPEN_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt    <= '0;
      glitch_cnt <= '0;
    end else begin
      if (we && (hit_cnt != 16'hffff)) hit_cnt <= hit_cnt + 16'd1;
      if (glitch && (glitch_cnt != 16'hffff)) glitch_cnt <= glitch_cnt + 16'd1;
    end
  end
`else
  logic glitch_unused;
  assign glitch_unused = glitch;
`endif

endmodule

// File: tb/tb_light_pen_frontend.sv
// Directed bench for light_pen_frontend: scans 8x8 frames with a 4-clk dwell and lights the pen
// LAT_CYC clk after a chosen pixel is scanned. Build with LPEN_STATS_EN to cover the counters.
module tb_light_pen_frontend;

  localparam int DW  = 4;
  localparam int LAT = 3;
  localparam int PW  = 5;

  logic       clk, rst_n, pen_in, pen_en;
  logic [7:0] led_row, led_col;
  logic       we, hit_valid, pen_level;
  logic [2:0] hit_row, hit_col;
  logic [1:0] fsm_state;
`ifdef LPEN_STATS_EN
  logic [15:0] hit_cnt, glitch_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [5:0] exp_q[$];
  int we_n, we_k, lvl, st_off;

  light_pen_frontend dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pen_in   (pen_in),
    .pen_en   (pen_en),
    .led_row  (led_row),
    .led_col  (led_col),
    .we       (we),
    .hit_row  (hit_row),
    .hit_col  (hit_col),
    .hit_valid(hit_valid),
    .pen_level(pen_level),
    .fsm_state(fsm_state)
`ifdef LPEN_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .glitch_cnt(glitch_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full frame of scan; pen lit for pw clk starting LAT clk after lit_pix is scanned.
  task automatic scan_frame(input int lit_pix, input int pw, input int en_off_k,
                            output int o_we_n, output int o_we_k, output int o_lvl,
                            output int o_st_off);
    o_we_n = 0; o_we_k = -1; o_lvl = 0; o_st_off = -1;
    for (int k = 0; k < 64 * DW; k++) begin
      int p;
      p       = k / DW;
      led_row = 8'd1 << (p / 8);
      led_col = 8'd1 << (p % 8);
      pen_in  = (lit_pix >= 0) && (k >= lit_pix * DW + LAT) && (k < lit_pix * DW + LAT + pw);
      pen_en  = !((en_off_k >= 0) && (k >= en_off_k));
      @(posedge clk);
      #1;
      if (we) begin
        o_we_n++;
        if (o_we_k < 0) o_we_k = k;
      end
      if (pen_level) o_lvl = 1;
      if (k == en_off_k) o_st_off = int'(fsm_state);
    end
    pen_in = 1'b0;
  endtask

  task automatic lit_frame(input string tag, input int pix);
    scan_frame(pix, PW, -1, we_n, we_k, lvl, st_off);
    check({tag, "_no_we"}, we_n, 0);
  endtask

  // Scoreboard: expected pixel pushed before the frame, popped when the we frame completes.
  task automatic we_frame(input string tag, input int lit_pix, input int exp_pix);
    logic [5:0] e;
    exp_q.push_back(6'(exp_pix));
    scan_frame(lit_pix, PW, -1, we_n, we_k, lvl, st_off);
    e = exp_q.pop_front();
    check({tag, "_we_count"}, we_n, 1);
    check({tag, "_we_pos"}, we_k, int'(e) * DW);
    check({tag, "_hit_row"}, hit_row, e[5:3]);
    check({tag, "_hit_col"}, hit_col, e[2:0]);
    check({tag, "_hit_valid"}, hit_valid, 1);
  endtask

  initial begin
    rst_n = 1'b0; pen_in = 1'b0; pen_en = 1'b1; led_row = '0; led_col = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_we", we, 0);
    check("rst_hit_valid", hit_valid, 0);
    check("rst_pen_level", pen_level, 0);
    check("rst_hit_pix", {hit_row, hit_col}, 0);
    check("rst_state", fsm_state, 0);

    // short pen pulse is filtered out
    scan_frame(10, 3, -1, we_n, we_k, lvl, st_off);
    check("glitch_level", lvl, 0);
    check("glitch_we", we_n, 0);
    check("glitch_state", fsm_state, 0);
`ifdef LPEN_STATS_EN
    check("glitch_cnt", glitch_cnt, 1);
`endif

    // (2,5) hit in two frames, we in the third
    lit_frame("t2_f1", 21);
    check("t2_f1_state", fsm_state, 1);
    lit_frame("t2_f2", 21);
    check("t2_f2_state", fsm_state, 2);
    we_frame("t2_f3", 21, 21);
    check("t2_lock", fsm_state, 3);

    // lock held while lit, dropped after a frame without pen
    lit_frame("t4_f4", 21);
    check("t4_f4_valid", hit_valid, 1);
    scan_frame(-1, PW, -1, we_n, we_k, lvl, st_off);
    check("t4_f5_we", we_n, 0);
    check("t4_f5_valid", hit_valid, 1);
    scan_frame(-1, PW, -1, we_n, we_k, lvl, st_off);
    check("t4_f6_we", we_n, 0);
    check("t4_f6_valid", hit_valid, 0);
    check("t4_f6_state", fsm_state, 0);
    check("t4_keep_row", hit_row, 2);

    // candidate moves from (2,5) to (3,5)
    lit_frame("t3_f1", 21);
    lit_frame("t3_f2", 29);
    check("t3_f2_state", fsm_state, 1);
    lit_frame("t3_f3", 29);
    check("t3_f3_state", fsm_state, 2);
    we_frame("t3_f4", -1, 29);

    // pen_en dropped while armed
    lit_frame("t5_f1", 21);
    lit_frame("t5_f2", 21);
    check("t5_armed", fsm_state, 2);
    scan_frame(-1, PW, 10, we_n, we_k, lvl, st_off);
    check("t5_we", we_n, 0);
    check("t5_state_next", st_off, 0);
    check("t5_valid", hit_valid, 0);
`ifdef LPEN_STATS_EN
    check("stats_hit_cnt", hit_cnt, 2);
    check("stats_glitch_cnt", glitch_cnt, 1);
`endif

    // asynchronous reset in the middle of CAND
    lit_frame("t6_pre", 21);
    check("t6_pre_state", fsm_state, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_state", fsm_state, 0);
    check("t6_rst_we", we, 0);
    check("t6_rst_level", pen_level, 0);
    check("t6_rst_hit_pix", {hit_row, hit_col}, 0);
    scan_frame(21, PW, -1, we_n, we_k, lvl, st_off);
    check("t6_held_we", we_n, 0);
    check("t6_held_state", fsm_state, 0);
`ifdef LPEN_STATS_EN
    check("t6_rst_hit_cnt", hit_cnt, 0);
    check("t6_rst_glitch_cnt", glitch_cnt, 0);
`endif
    rst_n = 1'b1;
    lit_frame("t6_a", 21);
    check("t6_a_state", fsm_state, 1);
    lit_frame("t6_b", 21);
    we_frame("t6_c", -1, 21);
`ifdef LPEN_STATS_EN
    check("t6_hit_cnt", hit_cnt, 1);
`endif
    check("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
